// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg
// Shared definitions for the UART command parser: FSM state encoding,
// ASCII constants used by the line decoder, and a terminator test helper.
// Configuration macro: UART_CMD_ERR_REPLY_EN adds the ERR_TX state.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    SKIP    = 3'd2,
    EXEC    = 3'd3,
    TX_HI   = 3'd4,
    TX_LO   = 3'd5,
    TX_NL   = 3'd6
`ifdef UART_CMD_ERR_REPLY_EN
    , ERR_TX = 3'd7
`endif
  } state_t;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_O     = 8'h6F;
  localparam logic [7:0] ASCII_I     = 8'h69;
  localparam logic [7:0] ASCII_C     = 8'h63;
  localparam logic [7:0] ASCII_R     = 8'h72;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_L     = 8'h6C;
  localparam logic [7:0] ASCII_K     = 8'h6B;
  localparam logic [7:0] ASCII_S     = 8'h73;
  localparam logic [7:0] ASCII_T     = 8'h74;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_1     = 8'h31;
  localparam logic [7:0] ASCII_3     = 8'h33;
  localparam logic [7:0] ASCII_4     = 8'h34;

  function automatic logic is_term(input logic [7:0] c);
    return (c == ASCII_CR) || (c == ASCII_LF);
  endfunction

endpackage

// File: rtl/hex_nibble.sv
// hex_nibble
// Combinational ASCII <-> nibble converter.
// Ports:
//   i_ascii  - character to decode ('0'-'9', 'A'-'F', 'a'-'f')
//   i_nibble - nibble to encode
//   o_nibble - decoded value of i_ascii (0 when invalid)
//   o_valid  - i_ascii is a hex digit
//   o_ascii  - uppercase ASCII hex digit for i_nibble
module hex_nibble (
  input  logic [7:0] i_ascii,
  input  logic [3:0] i_nibble,
  output logic [3:0] o_nibble,
  output logic       o_valid,
  output logic [7:0] o_ascii
);

  // Decode one ASCII hex digit, both letter cases accepted
  always_comb begin
    o_nibble = 4'h0;
    o_valid  = 1'b0;
    if ((i_ascii >= 8'h30) && (i_ascii <= 8'h39)) begin
      o_nibble = 4'(i_ascii - 8'h30);
      o_valid  = 1'b1;
    end else if ((i_ascii >= 8'h41) && (i_ascii <= 8'h46)) begin
      o_nibble = 4'(i_ascii - 8'h37);
      o_valid  = 1'b1;
    end else if ((i_ascii >= 8'h61) && (i_ascii <= 8'h66)) begin
      o_nibble = 4'(i_ascii - 8'h57);
      o_valid  = 1'b1;
    end else begin
      o_nibble = 4'h0;
      o_valid  = 1'b0;
    end
  end

  // Encode a nibble as an uppercase ASCII hex digit
  always_comb begin
    if (i_nibble < 4'd10) begin
      o_ascii = 8'h30 + {4'h0, i_nibble};
    end else begin
      o_ascii = 8'h37 + {4'h0, i_nibble};
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
// Parses CR/LF terminated ASCII command lines from a UART receiver:
//   oNHH      -> out_pinN = 0xHH (N = 0..4)
//   clk0/clk1 -> out_clk,  rst0/rst1 -> out_rst
//   iN        -> reply with in_pinN as two uppercase hex chars + LF
// Ports:
//   sys_clk, sys_rst        - clock, synchronous active-high reset
//   rx_data, rx_valid       - received byte and its one-cycle strobe
//   in_pin0..3              - pins sampled by read commands
//   out_pin0..4, out_clk, out_rst - registered software-controlled outputs
//   tx_data, tx_valid, tx_ready   - response byte stream (valid/ready)
// Configuration macro: UART_CMD_ERR_REPLY_EN - malformed or overlong lines
// are answered with "?\n" through ERR_TX; otherwise they are dropped silently.
module uart_cmd_parser
  import uart_cmd_pkg::*;
(
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic [7:0] in_pin0,
  input  logic [7:0] in_pin1,
  input  logic [7:0] in_pin2,
  input  logic [7:0] in_pin3,
  output logic [7:0] out_pin0,
  output logic [7:0] out_pin1,
  output logic [7:0] out_pin2,
  output logic [7:0] out_pin3,
  output logic [7:0] out_pin4,
  output logic       out_clk,
  output logic       out_rst,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  state_t          r_state;
  logic [3:0][7:0] r_buf;
  logic [2:0]      r_len;
  logic [3:0]      r_snap_lo;

  logic       w_is_term;
  logic [3:0] w_hi_nib, w_lo_nib;
  logic       w_hi_ok, w_lo_ok;
  logic [3:0] w_enc_nib;
  logic [7:0] w_enc_ascii;
  logic [7:0] w_sel_pin;
  logic       w_cmd_out, w_cmd_clk, w_cmd_rst, w_cmd_rd;
  logic [7:0] w_unused_hi_ascii, w_unused_lo_ascii;
  logic [3:0] w_unused_enc_nib;
  logic       w_unused_enc_ok;

  assign w_is_term = is_term(rx_data);

  hex_nibble u_dec_hi (
    .i_ascii (r_buf[2]), .i_nibble(4'h0),
    .o_nibble(w_hi_nib), .o_valid (w_hi_ok), .o_ascii(w_unused_hi_ascii)
  );

  hex_nibble u_dec_lo (
    .i_ascii (r_buf[3]), .i_nibble(4'h0),
    .o_nibble(w_lo_nib), .o_valid (w_lo_ok), .o_ascii(w_unused_lo_ascii)
  );

  hex_nibble u_enc (
    .i_ascii (8'h00), .i_nibble(w_enc_nib),
    .o_nibble(w_unused_enc_nib), .o_valid(w_unused_enc_ok), .o_ascii(w_enc_ascii)
  );

  // Classify the buffered line; only consulted while in EXEC
  always_comb begin
    w_cmd_out = (r_len == 3'd4) && (r_buf[0] == ASCII_O) &&
                (r_buf[1] >= ASCII_0) && (r_buf[1] <= ASCII_4) && w_hi_ok && w_lo_ok;
    w_cmd_clk = (r_len == 3'd4) && (r_buf[0] == ASCII_C) && (r_buf[1] == ASCII_L) &&
                (r_buf[2] == ASCII_K) && ((r_buf[3] == ASCII_0) || (r_buf[3] == ASCII_1));
    w_cmd_rst = (r_len == 3'd4) && (r_buf[0] == ASCII_R) && (r_buf[1] == ASCII_S) &&
                (r_buf[2] == ASCII_T) && ((r_buf[3] == ASCII_0) || (r_buf[3] == ASCII_1));
    w_cmd_rd  = (r_len == 3'd2) && (r_buf[0] == ASCII_I) &&
                (r_buf[1] >= ASCII_0) && (r_buf[1] <= ASCII_3);
  end

  // Input pin selected by a read command
  always_comb begin
    case (r_buf[1][1:0])
      2'd0:    w_sel_pin = in_pin0;
      2'd1:    w_sel_pin = in_pin1;
      2'd2:    w_sel_pin = in_pin2;
      2'd3:    w_sel_pin = in_pin3;
      default: w_sel_pin = in_pin0;
    endcase
  end

  // High nibble is encoded straight from the pin in EXEC; low nibble from the snapshot
  always_comb begin
    if (r_state == EXEC) begin
      w_enc_nib = w_sel_pin[7:4];
    end else begin
      w_enc_nib = r_snap_lo;
    end
  end

  // Line collection, command execution and response FSM
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state   <= IDLE;
      r_buf     <= '0;
      r_len     <= 3'd0;
      r_snap_lo <= 4'h0;
      out_pin0  <= 8'h00;
      out_pin1  <= 8'h00;
      out_pin2  <= 8'h00;
      out_pin3  <= 8'h00;
      out_pin4  <= 8'h00;
      out_clk   <= 1'b0;
      out_rst   <= 1'b0;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // A terminator here is an empty line (including the LF of CRLF)
          if (rx_valid && !w_is_term) begin
            r_buf[0] <= rx_data;
            r_len    <= 3'd1;
            r_state  <= COLLECT;
          end
        end
        COLLECT: begin
          if (rx_valid) begin
            if (w_is_term) begin
              r_state <= EXEC;
            end else if (r_len == 3'd4) begin
              r_state <= SKIP;
            end else begin
              r_buf[r_len[1:0]] <= rx_data;
              r_len             <= r_len + 3'd1;
            end
          end
        end
        SKIP: begin
          if (rx_valid && w_is_term) begin
            r_len <= 3'd0;
`ifdef UART_CMD_ERR_REPLY_EN
            tx_data  <= ASCII_QMARK;
            tx_valid <= 1'b1;
            r_state  <= ERR_TX;
`else
            r_state  <= IDLE;
`endif
          end
        end
        EXEC: begin
          r_len   <= 3'd0;
          r_state <= IDLE;
          if (w_cmd_out) begin
            case (r_buf[1][2:0])
              3'd0:    out_pin0 <= {w_hi_nib, w_lo_nib};
              3'd1:    out_pin1 <= {w_hi_nib, w_lo_nib};
              3'd2:    out_pin2 <= {w_hi_nib, w_lo_nib};
              3'd3:    out_pin3 <= {w_hi_nib, w_lo_nib};
              3'd4:    out_pin4 <= {w_hi_nib, w_lo_nib};
              default: out_pin0 <= out_pin0;
            endcase
          end else if (w_cmd_clk) begin
            out_clk <= r_buf[3][0];
          end else if (w_cmd_rst) begin
            out_rst <= r_buf[3][0];
          end else if (w_cmd_rd) begin
            r_snap_lo <= w_sel_pin[3:0];
            tx_data   <= w_enc_ascii;
            tx_valid  <= 1'b1;
            r_state   <= TX_HI;
          end else begin
`ifdef UART_CMD_ERR_REPLY_EN
            tx_data  <= ASCII_QMARK;
            tx_valid <= 1'b1;
            r_state  <= ERR_TX;
`else
            r_state  <= IDLE;
`endif
          end
        end
        TX_HI: begin
          if (tx_ready) begin
            tx_data <= w_enc_ascii;
            r_state <= TX_LO;
          end
        end
        TX_LO: begin
          if (tx_ready) begin
            tx_data <= ASCII_LF;
            r_state <= TX_NL;
          end
        end
        TX_NL: begin
          if (tx_ready) begin
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            r_state  <= IDLE;
          end
        end
`ifdef UART_CMD_ERR_REPLY_EN
        ERR_TX: begin
          if (tx_ready) begin
            tx_data <= ASCII_LF;
            r_state <= TX_NL;
          end
        end
`endif
        default: begin
          tx_valid <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
module tb_uart_cmd_parser;
  import uart_cmd_pkg::*;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  logic       sys_clk, sys_rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] in_pin0, in_pin1, in_pin2, in_pin3;
  logic [7:0] out_pin0, out_pin1, out_pin2, out_pin3, out_pin4;
  logic       out_clk, out_rst;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  uart_cmd_parser dut (
    .sys_clk (sys_clk),  .sys_rst (sys_rst),
    .rx_data (rx_data),  .rx_valid(rx_valid),
    .in_pin0 (in_pin0),  .in_pin1 (in_pin1), .in_pin2(in_pin2), .in_pin3(in_pin3),
    .out_pin0(out_pin0), .out_pin1(out_pin1), .out_pin2(out_pin2),
    .out_pin3(out_pin3), .out_pin4(out_pin4),
    .out_clk (out_clk),  .out_rst (out_rst),
    .tx_data (tx_data),  .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Monitor: every byte presented on tx must match the scoreboard head
  always @(negedge sys_clk) begin
    if (!sys_rst && tx_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL tx_unexpected: got 0x%02h, expected no byte", tx_data);
      end else begin
        if (tx_data !== exp_q[0]) begin
          n_fail++;
          $display("FAIL tx_byte: got 0x%02h, expected 0x%02h", tx_data, exp_q[0]);
        end
        if (tx_ready === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_line(input string s, input logic [7:0] term);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    send_byte(term);
  endtask

  task automatic wait_tx_done(input string name);
    int cyc;
    tick(2);
    cyc = 0;
    while ((tx_valid !== 1'b0 || exp_q.size() != 0) && cyc < 200) begin
      tick(1);
      cyc++;
    end
    n_checks++;
    if (cyc >= 200) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending bytes, expected 0", name, exp_q.size());
    end
  endtask

  task automatic push_err_reply();
`ifdef UART_CMD_ERR_REPLY_EN
    exp_q.push_back(8'h3F);
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic chk_pins(input string tag, input logic [7:0] p0, input logic [7:0] p1,
                          input logic [7:0] p2, input logic [7:0] p3, input logic [7:0] p4);
    chk({tag, "_pin0"}, out_pin0, p0);
    chk({tag, "_pin1"}, out_pin1, p1);
    chk({tag, "_pin2"}, out_pin2, p2);
    chk({tag, "_pin3"}, out_pin3, p3);
    chk({tag, "_pin4"}, out_pin4, p4);
  endtask

  initial begin
    sys_rst  = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    in_pin0  = 8'hA5;
    in_pin1  = 8'h3C;
    in_pin2  = 8'h90;
    in_pin3  = 8'h7E;
    tick(3);
    sys_rst = 1'b0;

    // Reset state
    chk_pins("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("reset_clk", {7'd0, out_clk}, 8'h00);
    chk("reset_rst", {7'd0, out_rst}, 8'h00);
    chk("reset_txv", {7'd0, tx_valid}, 8'h00);
    chk("reset_txd", tx_data, 8'h00);

    // Malformed lines: non-hex, bad index, too long, uppercase keyword
    push_err_reply(); send_line("o4zz", LF);  wait_tx_done("err_hex");
    push_err_reply(); send_line("o50A", LF);  wait_tx_done("err_idx");
    push_err_reply(); send_line("o4012", LF); wait_tx_done("err_long");
    push_err_reply(); send_line("O1AB", LF);  wait_tx_done("err_upper");
    chk_pins("err", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    // Write with exact update latency: not yet one cycle after CR, set the next
    send_line("o256", CR);
    chk("o256_early", out_pin2, 8'h00);
    tick(1);
    chk_pins("o256", 8'h00, 8'h00, 8'h56, 8'h00, 8'h00);

    // More writes, lowercase and mixed-case hex
    send_line("o402", LF); tick(2);
    send_line("o1ab", LF); tick(2);
    send_line("o3Fe", CR); tick(2);
    chk_pins("wr", 8'h00, 8'hAB, 8'h56, 8'hFE, 8'h02);

    // Read in_pin1 = 0x3C with 5-cycle stalls before each byte
    tx_ready = 1'b0;
    exp_q.push_back(8'h33); exp_q.push_back(8'h43); exp_q.push_back(8'h0A);
    send_line("i1", LF);
    for (int k = 0; k < 3; k++) begin
      tick(5);
      chk("rd_stall_valid", {7'd0, tx_valid}, 8'h01);
      tx_ready = 1'b1;
      tick(1);
      tx_ready = 1'b0;
    end
    tx_ready = 1'b1;
    wait_tx_done("rd_i1");

    // clk/rst keywords, CRLF counted as one command
    send_line("clk1", CR); send_byte(LF); tick(2);
    send_line("rst1", LF); tick(2);
    chk("clk1", {7'd0, out_clk}, 8'h01);
    chk("rst1", {7'd0, out_rst}, 8'h01);
    exp_q.push_back(8'h39); exp_q.push_back(8'h30); exp_q.push_back(8'h0A);
    send_line("i2", CR); send_byte(LF);
    wait_tx_done("rd_crlf");
    send_line("clk0", LF); tick(2);
    chk("clk0", {7'd0, out_clk}, 8'h00);
    chk("rst_hold", {7'd0, out_rst}, 8'h01);

    // Bytes strobed during TX states must be dropped
    tx_ready = 1'b0;
    exp_q.push_back(8'h37); exp_q.push_back(8'h45); exp_q.push_back(8'h0A);
    send_line("i3", LF);
    tick(2);
    send_line("o311", LF);
    tx_ready = 1'b1; tick(1); tx_ready = 1'b0;
    send_line("o312", LF);
    tx_ready = 1'b1;
    wait_tx_done("rd_drop");
    chk("drop_pin3", out_pin3, 8'hFE);
    send_line("o322", LF); tick(2);
    chk("after_drop_pin3", out_pin3, 8'h22);

    // Reset while in TX_LO of a read of in_pin0 = 0xA5
    tx_ready = 1'b0;
    exp_q.push_back(8'h41); exp_q.push_back(8'h35);
    send_line("i0", LF);
    tick(3);
    tx_ready = 1'b1; tick(1); tx_ready = 1'b0;
    tick(2);
    chk("txlo_state", 8'(dut.r_state), 8'(TX_LO));
    chk("txlo_data", tx_data, 8'h35);
    sys_rst = 1'b1;
    tick(1);
    exp_q.delete();
    chk("rst_txv", {7'd0, tx_valid}, 8'h00);
    chk("rst_txd", tx_data, 8'h00);
    chk("rst_state", 8'(dut.r_state), 8'(IDLE));
    chk("rst_clk", {7'd0, out_clk}, 8'h00);
    chk("rst_rst", {7'd0, out_rst}, 8'h00);
    chk_pins("rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    sys_rst  = 1'b0;
    tx_ready = 1'b1;
    tick(5);
    chk("no_resume_txv", {7'd0, tx_valid}, 8'h00);
    send_line("o0FF", LF); tick(2);
    chk_pins("post_rst", 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);

    tick(3);
    chk("queue_empty", 8'(exp_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
